// File: rtl/retire_queue.sv
// In-order retire queue: compacted multi-lane allocate, head-run retire,
// registered release strobes back to the tag freelist.
module retire_queue #(
  parameter int DEPTH = 16,
  parameter int DATA  = 4,
  parameter int ALLOC = 4,
  parameter int RET   = 4
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    flush_,
  input  logic [ALLOC-1:0]        alloc_,
  input  logic [ALLOC*DATA-1:0]   alloc_d,
  input  logic [RET-1:0]          commit_,
  output logic [RET*DATA-1:0]     hd,
  output logic [RET-1:0]          hv,
  output logic [RET-1:0]          rel_we_,
  output logic [RET*DATA-1:0]     rel_wd,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [DATA-1:0]     mem_q [DEPTH];
  ptr_t                head_q, head_d;
  ptr_t                tail_q, tail_d;
  cnt_t                count_q, count_d;
  logic [RET-1:0]      rel_we_q, rel_we_d;
  logic [RET*DATA-1:0] rel_wd_q, rel_wd_d;

  cnt_t             a_cnt;
  cnt_t             k_cnt;
  logic             run;
  logic [ALLOC-1:0] wr_en;
  ptr_t             wr_idx [ALLOC];
  logic [RET-1:0]   ret_lane;

  assign busy    = (cnt_t'(DEPTH) - count_q) < cnt_t'(ALLOC);
  assign count   = count_q;
  assign rel_we_ = rel_we_q;
  assign rel_wd  = rel_wd_q;

  always_comb begin
    hd = '0;
    hv = '0;
    for (int i = 0; i < RET; i++) begin
      hd[i*DATA +: DATA] = mem_q[head_q + ptr_t'(i)];
      hv[i] = cnt_t'(i) < count_q;
    end
  end

  // Compaction: each asserted lane takes the next free slot after tail.
  always_comb begin
    a_cnt = '0;
    wr_en = '0;
    for (int i = 0; i < ALLOC; i++) begin
      wr_idx[i] = tail_q + a_cnt[PW-1:0];
      if (!alloc_[i] && !busy && flush_) begin
        wr_en[i] = 1'b1;
        a_cnt    = a_cnt + cnt_t'(1);
      end
    end
  end

  always_comb begin
    k_cnt    = '0;
    run      = 1'b1;
    ret_lane = '0;
    for (int i = 0; i < RET; i++) begin
      if (run && !commit_[i] && (cnt_t'(i) < count_q)) begin
        ret_lane[i] = 1'b1;
        k_cnt       = k_cnt + cnt_t'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    head_d   = head_q + k_cnt[PW-1:0];
    tail_d   = tail_q + a_cnt[PW-1:0];
    count_d  = count_q + a_cnt - k_cnt;
    rel_we_d = ~ret_lane;
    rel_wd_d = hd;
    if (!flush_) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      rel_we_d = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rel_we_q <= '1;
      rel_wd_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rel_we_q <= rel_we_d;
      rel_wd_q <= rel_wd_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ALLOC; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= alloc_d[i*DATA +: DATA];
    end
  end

endmodule

// File: tb/tb_retire_queue.sv
// Scoreboard bench for retire_queue: directed stimulus pushes expected
// releases, a negedge monitor pops and compares them.
module tb_retire_queue;

  logic        clk = 1'b0;
  logic        reset_;
  logic        flush_;
  logic [3:0]  alloc_;
  logic [15:0] alloc_d;
  logic [3:0]  commit_;
  logic [15:0] hd;
  logic [3:0]  hv;
  logic [3:0]  rel_we_;
  logic [15:0] rel_wd;
  logic        busy;
  logic [4:0]  count;

  typedef struct {
    logic [3:0]  we;
    logic [15:0] wd;
  } rel_t;

  rel_t sb[$];
  int   checks = 0;
  int   errors = 0;

  retire_queue #(.DEPTH(16), .DATA(4), .ALLOC(4), .RET(4)) dut (
    .clk(clk), .reset_(reset_), .flush_(flush_),
    .alloc_(alloc_), .alloc_d(alloc_d), .commit_(commit_),
    .hd(hd), .hv(hv), .rel_we_(rel_we_), .rel_wd(rel_wd),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alloc_  = 4'hF;
    commit_ = 4'hF;
    flush_  = 1'b1;
  endtask

  task automatic push(input logic [3:0] we, input logic [15:0] wd);
    rel_t r;
    r.we = we;
    r.wd = wd;
    sb.push_back(r);
  endtask

  function automatic logic [3:0] tg(input int n);
    return 4'((n * 5 + 3) % 16);
  endfunction

  always @(negedge clk) begin
    if (reset_ && rel_we_ !== 4'hF) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rel_unexpected: got we=%b wd=%h expected none",
                 rel_we_, rel_wd);
      end else begin
        rel_t e;
        logic [15:0] m;
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) m[i*4 +: 4] = {4{~e.we[i]}};
        if (rel_we_ !== e.we || (rel_wd & m) !== (e.wd & m)) begin
          errors++;
          $display("FAIL rel: got we=%b wd=%h expected we=%b wd=%h",
                   rel_we_, rel_wd & m, e.we, e.wd & m);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_  = 1'b0;
    alloc_d = '0;
    idle();
    repeat (3) cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_hv", 32'(hv), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(rel_we_), 32'hF);
    chk("rst_wd", 32'(rel_wd), 0);
    reset_ = 1'b1;
    cyc();

    alloc_ = 4'b1100; alloc_d = 16'hFF10;
    cyc(); idle();
    chk("a01_count", 32'(count), 2);
    chk("a01_hv", 32'(hv), 32'h3);
    chk("a01_hd", 32'(hd[7:0]), 32'h10);
    chk("a01_we", 32'(rel_we_), 32'hF);
    flush_ = 1'b0; cyc(); idle();
    chk("fl_count", 32'(count), 0);

    alloc_ = 4'b0101; alloc_d = 16'h93F7 ^ 16'h0300;
    alloc_d = {4'd9, 4'd3, 4'd7, 4'd15};
    cyc(); idle();
    chk("cmp_hd0", 32'(hd[3:0]), 7);
    chk("cmp_hd1", 32'(hd[7:4]), 9);
    chk("cmp_count", 32'(count), 2);
    flush_ = 1'b0; cyc(); idle();

    alloc_ = 4'b0000; alloc_d = 16'h3210; cyc();
    alloc_ = 4'b1110; alloc_d = 16'hEEE4; cyc(); idle();
    chk("c5_count", 32'(count), 5);
    commit_ = 4'b0100; push(4'b1100, 16'h0010);
    cyc(); idle();
    chk("run_count", 32'(count), 3);
    chk("run_hd0", 32'(hd[3:0]), 2);
    commit_ = 4'b0000; push(4'b1000, 16'h0432);
    cyc(); idle();
    chk("clip_count", 32'(count), 0);
    commit_ = 4'b0000; cyc(); idle();
    chk("empty_we", 32'(rel_we_), 32'hF);
    chk("empty_count", 32'(count), 0);

    alloc_ = 4'b0000;
    alloc_d = 16'h3210; cyc();
    alloc_d = 16'h7654; cyc();
    alloc_d = 16'hBA98; cyc();
    alloc_ = 4'b1110; alloc_d = 16'h000C; cyc(); idle();
    chk("c13_count", 32'(count), 13);
    chk("c13_busy", 32'(busy), 1);
    alloc_ = 4'b0000; alloc_d = 16'h0FED;
    commit_ = 4'b1100; push(4'b1100, 16'h0010);
    cyc(); idle();
    chk("c11_count", 32'(count), 11);
    chk("c11_busy", 32'(busy), 0);
    chk("c11_hd0", 32'(hd[3:0]), 2);
    commit_ = 4'b0000; push(4'b0000, 16'h5432); cyc();
    push(4'b0000, 16'h9876); cyc();
    push(4'b1000, 16'h0CBA); cyc(); idle();
    chk("drain_count", 32'(count), 0);

    alloc_ = 4'b0000;
    alloc_d = 16'h3210; cyc();
    alloc_d = 16'h7654; cyc();
    alloc_d = 16'hBA98; cyc();
    alloc_d = 16'hFEDC; cyc(); idle();
    chk("full_count", 32'(count), 16);
    chk("full_busy", 32'(busy), 1);
    chk("full_hv", 32'(hv), 32'hF);
    alloc_ = 4'b0000; alloc_d = 16'h5555;
    commit_ = 4'b0000; push(4'b0000, 16'h3210);
    cyc(); alloc_ = 4'hF;
    chk("full_ret", 32'(count), 12);
    push(4'b0000, 16'h7654); cyc();
    push(4'b0000, 16'hBA98); cyc();
    push(4'b0000, 16'hFEDC); cyc(); idle();
    chk("full_drain", 32'(count), 0);

    alloc_ = 4'b0000; alloc_d = 16'h4321; cyc(); idle();
    commit_ = 4'b0000;
    @(posedge clk);
    #1 reset_ = 1'b0;
    idle();
    #1;
    chk("mid_rst_we", 32'(rel_we_), 32'hF);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_hv", 32'(hv), 0);
    cyc(); reset_ = 1'b1; cyc();

    for (int c = 0; c < 6; c++) begin
      alloc_ = 4'b0000;
      commit_ = 4'b0000;
      for (int j = 0; j < 4; j++) alloc_d[j*4 +: 4] = tg(4*c + j);
      if (c > 0)
        push(4'b0000, {tg(4*c-1), tg(4*c-2), tg(4*c-3), tg(4*c-4)});
      cyc();
      chk("wrap_count", 32'(count), 4);
    end
    idle(); commit_ = 4'b0000;
    push(4'b0000, {tg(23), tg(22), tg(21), tg(20)});
    cyc(); idle();
    chk("wrap_end", 32'(count), 0);

    alloc_ = 4'b0000; alloc_d = 16'h3210; cyc();
    alloc_d = 16'h7654; commit_ = 4'b1100;
    push(4'b1100, 16'h0010);
    cyc(); idle();
    chk("c6_count", 32'(count), 6);
    flush_ = 1'b0; commit_ = 4'b0000;
    alloc_ = 4'b0000; alloc_d = 16'hAAAA;
    cyc(); idle();
    chk("fl6_count", 32'(count), 0);
    chk("fl6_hv", 32'(hv), 0);
    chk("fl6_we", 32'(rel_we_), 32'hF);
    alloc_ = 4'b1110; alloc_d = 16'h0009; cyc(); idle();
    chk("post_fl_hd0", 32'(hd[3:0]), 9);
    chk("post_fl_count", 32'(count), 1);

    repeat (3) cyc();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
